// File: rtl/rom_pkg.sv
// Shared types for the cartridge scan path: scan FSM states and colour codes.
// Also used by the downstream row decoder and the motion controller.
package rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [1:0] color_t;

  localparam color_t RED    = 2'd0;
  localparam color_t GREEN  = 2'd1;
  localparam color_t BLUE   = 2'd2;
  localparam color_t YELLOW = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nit_sampler.sv
// Per-nit colour sampler: keeps the first sample and flags any later disagreement.
// Outputs already reflect the sample presented in the current strobe cycle.
module nit_sampler
  import rom_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   strobe,
  input  color_t colorCode,
  output color_t value,
  output logic   mismatch
);

  logic   have;
  color_t first_q;
  logic   mism_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      have    <= 1'b0;
      first_q <= RED;
      mism_q  <= 1'b0;
    end else if (strobe) begin
      if (!have) begin
        have    <= 1'b1;
        first_q <= colorCode;
      end else if (colorCode != first_q) begin
        mism_q  <= 1'b1;
      end
    end
  end

  // Bypass so the last sample of a nit is visible in the cycle it arrives.
  assign value    = have ? first_q : colorCode;
  assign mismatch = mism_q | (strobe & have & (colorCode != first_q));

endmodule

// File: rtl/row_selector.sv
// Scan responder: walks the colour sensor mux over every nit column of a row,
// settles, samples, checks, and hands the assembled row back with a done pulse.
module row_selector
  import rom_pkg::*;
#(
  parameter  int COLUMNS       = 8,
  parameter  int SETTLE_CYCLES = 256,
  parameter  int SAMPLES       = 4,
  localparam int CW            = $clog2(COLUMNS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startSelector,
  input  logic [1:0]           colorCode,
  output logic [CW-1:0]        columnSelect,
  output logic                 sensorEnable,
  output logic [2*COLUMNS-1:0] rowData,
  output logic [COLUMNS-1:0]   rowError,
  output logic                 rowValid,
  output logic                 selectorComplete
);

  localparam int CNTW = $clog2(max_int(SETTLE_CYCLES, SAMPLES) + 1);

  state_t               state;
  logic [CNTW-1:0]      cnt;
  logic [2*COLUMNS-1:0] scratch_row, next_row;
  logic [COLUMNS-1:0]   scratch_err, next_err;
  logic                 strobe, clear, last_sample, last_column;
  color_t               nit_value;
  logic                 nit_mismatch;

  assign strobe      = (state == SAMPLE);
  assign last_sample = strobe && (cnt == CNTW'(SAMPLES - 1));
  assign last_column = (columnSelect == CW'(COLUMNS - 1));
  // Sampler is held clear while idle and wiped as each nit finishes.
  assign clear       = (state == IDLE) || last_sample;

  nit_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .strobe    (strobe),
    .colorCode (colorCode),
    .value     (nit_value),
    .mismatch  (nit_mismatch)
  );

  always_comb begin
    next_row = scratch_row;
    next_err = scratch_err;
    next_row[{columnSelect, 1'b0} +: 2] = nit_value;
    next_err[columnSelect]              = nit_mismatch;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      columnSelect     <= '0;
      sensorEnable     <= 1'b0;
      scratch_row      <= '0;
      scratch_err      <= '0;
      rowData          <= '0;
      rowError         <= '0;
      rowValid         <= 1'b0;
      selectorComplete <= 1'b0;
    end else begin
      rowValid         <= 1'b0;
      selectorComplete <= 1'b0;
      case (state)
        IDLE: begin
          if (startSelector) begin
            state        <= SETTLE;
            cnt          <= '0;
            columnSelect <= '0;
            sensorEnable <= 1'b1;
            scratch_row  <= '0;
            scratch_err  <= '0;
          end
        end
        SETTLE: begin
          if (cnt == CNTW'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (last_sample) begin
            cnt         <= '0;
            scratch_row <= next_row;
            scratch_err <= next_err;
            if (last_column) begin
              // Publish the row on the same edge that raises the done pulse.
              state            <= DONE;
              columnSelect     <= '0;
              sensorEnable     <= 1'b0;
              rowData          <= next_row;
              rowError         <= next_err;
              rowValid         <= 1'b1;
              selectorComplete <= 1'b1;
            end else begin
              state        <= SETTLE;
              columnSelect <= columnSelect + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/row_selector.md
# row_selector

Responder side of the scan handshake that drives the cartridge motion controller. After the carriage parks over a nit row, the motion controller pulses `startSelector`. This block then walks the colour sensor mux across every nit column, waits for each to settle, samples and checks the 2-bit colour code, and assembles the row word. It ends with a one-cycle `selectorComplete` pulse that releases the carriage to the next row.

## Interface
- COLUMNS, 8: nits per row; ≥2.
- SETTLE_CYCLES, 256: cycles after a column change before sampling; ≥1.
- SAMPLES, 4: colour samples taken per nit; ≥1.
- CW = $clog2(COLUMNS): column address width.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- startSelector  input  1  one-cycle start pulse from the motion controller.
- colorCode  input  2  current sensor colour: RED=0, GREEN=1, BLUE=2, YELLOW=3.
- columnSelect  output  CW  sensor mux address.
- sensorEnable  output  1  illumination/sensor enable.
- rowData  output  2*COLUMNS  colour of column i at bits [2i+1:2i].
- rowError  output  COLUMNS  bit i set if column i samples disagreed.
- rowValid  output  1  one-cycle pulse, coincident with selectorComplete.
- selectorComplete  output  1  one-cycle done pulse back to the motion controller.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE
  - `startSelector`=1 → SETTLE; column ← 0, counter ← 0, scratch row/error cleared.
  - `startSelector`=0 → stay in IDLE.
- SETTLE
  - Counts SETTLE_CYCLES cycles, then → SAMPLE with counter ← 0.
- SAMPLE
  - Captures `colorCode` once per cycle for SAMPLES cycles.
  - The first sample is the nit value.
  - Any later sample that differs from the first sets the column's scratch error bit.
  - After the last sample:
    - column < COLUMNS−1 → column+1, go to SETTLE.
    - Otherwise → DONE.
- DONE (exactly one cycle)
  - `selectorComplete`=1, `rowValid`=1.
  - `rowData`/`rowError` load the scratch values in this same cycle.
  - Then → IDLE.
  - `columnSelect` returns to 0.
- `sensorEnable`=1 exactly in SETTLE and SAMPLE.
- `rowData`/`rowError` hold their value until the next DONE; they never change mid-scan.
- `startSelector` is ignored outside IDLE, including in DONE.
- Back-to-back scans are allowed: a start in the first IDLE cycle after DONE begins a new scan.
- `colorCode` is sampled raw. The sensor path guarantees it is synchronous to `clk`.

## Timing
- Reset (`reset`=0 at a rising edge) forces:
  - state IDLE, counters 0;
  - `columnSelect`=0, `sensorEnable`=0;
  - `rowData`=0, `rowError`=0;
  - `rowValid`=0, `selectorComplete`=0.
- Reset mid-scan aborts the scan with no completion pulse.
- Latency: `startSelector` high in cycle 0 gives `selectorComplete` high in cycle COLUMNS*(SETTLE_CYCLES+SAMPLES)+1.
  - Defaults: cycle 2081.
- `columnSelect` changes on the edge that enters SETTLE. It is stable throughout the SETTLE and SAMPLE cycles for that column.
- `selectorComplete` is never high for two consecutive cycles. The motion controller counts rows on every high cycle.
- Counter width: $clog2(max(SETTLE_CYCLES,SAMPLES)+1). The counter never wraps inside a state.

## Structure
- Shared package `rom_pkg`:
  - state enum;
  - colour code constants RED/GREEN/BLUE/YELLOW.
- `rom_pkg` is reused by the downstream row decoder and the motion controller.
- One sub-module, `nit_sampler`:
  - inputs: clear, sample strobe, `colorCode`;
  - outputs: first-sample value, mismatch flag.
- `row_selector` instantiates one `nit_sampler`. It shifts the sampler's outputs into the scratch registers at the end of SAMPLE.

## Test plan
- Reset mid-scan: pull `reset` low during column 2 SETTLE → all outputs 0 next cycle, no `selectorComplete`. A following start gives a normal full scan.
- Nominal scan, bench parameters COLUMNS=4, SETTLE_CYCLES=3, SAMPLES=2:
  - Stimulus: start in cycle 0; `colorCode` driven as 3,2,1,0 for columns 0–3, keyed on `columnSelect`.
  - Response: `selectorComplete`/`rowValid` high only in cycle 21, `rowData`=8'b00_01_10_11, `rowError`=0.
- Sample mismatch: same setup, but column 1's second sample = 0 instead of 2 → `rowData`=8'b00_01_10_11, `rowError`=4'b0010.
- Start while busy: extra `startSelector` pulses in cycles 5 and 21 → ignored. Exactly one completion at cycle 21, then IDLE.
- Back-to-back: start in cycle 22 (first IDLE cycle) → second completion at cycle 43. `rowData` holds its first-scan value through cycles 22–42.
- Default parameters: 32 consecutive start/complete handshakes with the motion controller model → 32 completion pulses, each at start+2081, `sensorEnable` low between scans.
